plic_claim_complete: RTL and testbench



---
 rtl/plic_pkg.sv | 8 +
 rtl/plic_claim_complete_if.sv | 13 +
 rtl/plic_gateway.sv | 31 +++
 rtl/plic_claim_complete.sv | 87 ++++++++
 tb/tb_plic_claim_complete.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_pkg.sv
// plic_pkg: shared gateway state encoding, ID constants and source-to-ID mapping
package plic_pkg;
  typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_INSERV} gw_state_t;
  localparam int ID_NONE = 0;
  function automatic int src2id(input int n);
    return n + 1;
  endfunction
endpackage

// File: rtl/plic_claim_complete_if.sv
// plic_claim_complete_if: CPU claim/complete handshake and interrupt line
// master = CPU side (drives claim_i, complete_i, complete_id)
// slave  = PLIC side (drives eip_o, claim_ack_o, claim_id_o)
interface plic_claim_complete_if #(parameter int ID_W = 4);
  logic            claim_i;
  logic            complete_i;
  logic [ID_W-1:0] complete_id;
  logic            eip_o;
  logic            claim_ack_o;
  logic [ID_W-1:0] claim_id_o;
  modport master (output claim_i, complete_i, complete_id, input eip_o, claim_ack_o, claim_id_o);
  modport slave  (input claim_i, complete_i, complete_id, output eip_o, claim_ack_o, claim_id_o);
endinterface

// File: rtl/plic_gateway.sv
// plic_gateway: per-source IDLE -> PENDING -> INSERV -> IDLE gateway
// ports: clk, rst (sync, active-high), req (sensed request), claim_hit (this
// source claimed), complete_hit (this source completed); pending/inserv are
// registered state flags
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending,
  output logic inserv
);
  gw_state_t state_q, state_d;
  always_comb
    state_d = (state_q == GW_IDLE    && req)          ? GW_PENDING :
              (state_q == GW_PENDING && claim_hit)    ? GW_INSERV  :
              (state_q == GW_INSERV  && complete_hit) ? GW_IDLE    : state_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= GW_IDLE;
      pending <= 1'b0;
      inserv  <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= state_d == GW_PENDING;
      inserv  <= state_d == GW_INSERV;
    end
endmodule

// File: rtl/plic_claim_complete.sv
// plic_claim_complete: PLIC target side - gateways, priority arbitration, claim/complete
// ports: pclk, preset (sync, active-high); irq_req per-source requests;
// irq_prio packed priorities; prio_thresh; bus (slave modport: claim/complete
// handshake, eip_o, claim_ack_o, claim_id_o); pending_o gateway pending bits.
// Optional macro PLIC_NMI_BYPASS_EN: source 0 becomes an NMI that always wins,
// is excluded from eip_o and reported on the extra registered output nmi_o.
module plic_claim_complete
  import plic_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 4
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_SRC-1:0]        irq_req,
  input  logic [NUM_SRC*PRIO_W-1:0] irq_prio,
  input  logic [PRIO_W-1:0]         prio_thresh,
  plic_claim_complete_if.slave      bus,
  output logic [NUM_SRC-1:0]        pending_o
`ifdef PLIC_NMI_BYPASS_EN
  ,
  output logic                      nmi_o
`endif
);
`ifdef PLIC_NMI_BYPASS_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  logic [NUM_SRC-1:0] pending, inserv, claim_hit, complete_hit;
  logic [ID_W-1:0]    arb_id, win_id, id_q, id_d;
  logic [PRIO_W-1:0]  best;
  logic               eip_q, eip_d, ack_q;
  // Scanning upward with a strict '>' keeps the lowest index on priority ties.
  always_comb begin
    arb_id = ID_W'(ID_NONE);
    best   = '0;
    for (int n = FIRST; n < NUM_SRC; n++)
      if (pending[n] && irq_prio[n*PRIO_W +: PRIO_W] > prio_thresh &&
          (arb_id == ID_W'(ID_NONE) || irq_prio[n*PRIO_W +: PRIO_W] > best)) begin
        best   = irq_prio[n*PRIO_W +: PRIO_W];
        arb_id = ID_W'(src2id(n));
      end
  end
`ifdef PLIC_NMI_BYPASS_EN
  assign win_id = pending[0] ? ID_W'(src2id(0)) : arb_id;
`else
  assign win_id = arb_id;
`endif
  assign eip_d = arb_id != ID_W'(ID_NONE);
  assign id_d  = bus.claim_i ? win_id : id_q;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_gw
    assign claim_hit[i]    = bus.claim_i && win_id == ID_W'(src2id(i));
    assign complete_hit[i] = bus.complete_i && inserv[i] && bus.complete_id == ID_W'(src2id(i));
    plic_gateway u_gw (
      .clk          (pclk),
      .rst          (preset),
      .req          (irq_req[i]),
      .claim_hit    (claim_hit[i]),
      .complete_hit (complete_hit[i]),
      .pending      (pending[i]),
      .inserv       (inserv[i])
    );
  end
  always_ff @(posedge pclk)
    if (preset) begin
      eip_q <= 1'b0;
      ack_q <= 1'b0;
      id_q  <= '0;
    end else begin
      eip_q <= eip_d;
      ack_q <= bus.claim_i;
      id_q  <= id_d;
    end
`ifdef PLIC_NMI_BYPASS_EN
  logic nmi_q;
  always_ff @(posedge pclk)
    if (preset) nmi_q <= 1'b0;
    else        nmi_q <= pending[0];
  assign nmi_o = nmi_q;
`endif
  assign bus.eip_o       = eip_q;
  assign bus.claim_ack_o = ack_q;
  assign bus.claim_id_o  = id_q;
  assign pending_o       = pending;
endmodule

// File: tb/tb_plic_claim_complete.sv
// tb_plic_claim_complete: directed literal checks plus random stimulus against a behavioural model
module tb_plic_claim_complete;
`ifdef PLIC_NMI_BYPASS_EN
  localparam bit NMI = 1'b1;
`else
  localparam bit NMI = 1'b0;
`endif
  typedef int st_t[8];
  logic        pclk = 1'b0, preset = 1'b1;
  logic [7:0]  irq_req = '0;
  logic [23:0] irq_prio = '0;
  logic [2:0]  prio_thresh = '0;
  logic [7:0]  pending_o;
  logic        nmi;
  int          tests = 0, fails = 0;
  st_t         st;
  bit          m_eip, m_ack, m_nmi, armed = 1'b0;
  int          m_id;
  logic [7:0]  m_pend;
  plic_claim_complete_if #(.ID_W(4)) bus();
  plic_claim_complete dut (
    .pclk        (pclk),
    .preset      (preset),
    .irq_req     (irq_req),
    .irq_prio    (irq_prio),
    .prio_thresh (prio_thresh),
    .bus         (bus),
    .pending_o   (pending_o)
`ifdef PLIC_NMI_BYPASS_EN
    ,
    .nmi_o       (nmi)
`endif
  );
`ifndef PLIC_NMI_BYPASS_EN
  assign nmi = 1'b0;
`endif
  always #5 pclk = ~pclk;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Model states: 0 idle, 1 pending, 2 in service.
  // Search priorities from the top down and indices from the bottom up.
  function automatic int scan(input bit skip0);
    int r = 0;
    for (int p = 7; p >= 1; p--)
      if (p > int'(prio_thresh))
        for (int n = (skip0 ? 1 : 0); n < 8; n++)
          if (r == 0 && st[n] == 1 && int'(irq_prio[n*3 +: 3]) == p) r = n + 1;
    return r;
  endfunction
  function automatic int winner();
    return (NMI && st[0] == 1) ? 1 : scan(NMI);
  endfunction
  function automatic st_t next_st();
    st_t r = st;
    int w = winner();
    for (int n = 0; n < 8; n++)
      if (st[n] == 0 && irq_req[n]) r[n] = 1;
      else if (st[n] == 1 && bus.claim_i && w == n + 1) r[n] = 2;
      else if (st[n] == 2 && bus.complete_i && int'(bus.complete_id) == n + 1) r[n] = 0;
    return r;
  endfunction
  function automatic logic [7:0] pend_of(input st_t s);
    logic [7:0] v = '0;
    for (int n = 0; n < 8; n++) v[n] = s[n] == 1;
    return v;
  endfunction
  always @(posedge pclk)
    if (preset) begin
      st     <= '{default: 0};
      m_eip  <= 1'b0;
      m_ack  <= 1'b0;
      m_id   <= 0;
      m_pend <= '0;
      m_nmi  <= 1'b0;
      armed  <= 1'b1;
    end else begin
      m_eip  <= scan(NMI) != 0;
      m_ack  <= bus.claim_i;
      if (bus.claim_i) m_id <= winner();
      m_nmi  <= st[0] == 1;
      m_pend <= pend_of(next_st());
      st     <= next_st();
    end
  always @(negedge pclk)
    if (armed) begin
      chk("eip", bus.eip_o, m_eip);
      chk("ack", bus.claim_ack_o, m_ack);
      chk("id", bus.claim_id_o, m_id);
      chk("pending", pending_o, m_pend);
      if (NMI) chk("nmi", nmi, m_nmi);
    end
  task automatic step();
    @(negedge pclk);
  endtask
  task automatic do_cyc(input bit c, input bit k, input int id);
    bus.claim_i = c;
    bus.complete_i = k;
    bus.complete_id = 4'(id);
    step();
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b0;
    bus.complete_id = '0;
  endtask
  task automatic pulse(input logic [7:0] m);
    irq_req = m;
    step();
    irq_req = '0;
  endtask
  task automatic set_prio(input int n, input int p);
    irq_prio[n*3 +: 3] = 3'(p);
  endtask
  initial begin
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b0;
    bus.complete_id = '0;
    repeat (2) step();
    preset = 1'b0;
    chk("rst_eip", bus.eip_o, 0);
    chk("rst_ack", bus.claim_ack_o, 0);
    chk("rst_id", bus.claim_id_o, 0);
    chk("rst_pend", pending_o, 0);
    // single source
    set_prio(2, 5);
    prio_thresh = 3'd1;
    pulse(8'h04);
    chk("s1_pend", pending_o, 8'h04);
    chk("s1_eip0", bus.eip_o, 0);
    step();
    chk("s1_eip1", bus.eip_o, 1);
    do_cyc(1, 0, 0);
    chk("s1_ack", bus.claim_ack_o, 1);
    chk("s1_id", bus.claim_id_o, 3);
    chk("s1_pend_clr", pending_o, 0);
    step();
    chk("s1_eip_clr", bus.eip_o, 0);
    chk("s1_ack_clr", bus.claim_ack_o, 0);
    chk("s1_id_hold", bus.claim_id_o, 3);
    do_cyc(0, 1, 3);
    pulse(8'h04);
    chk("s1_rearm", pending_o, 8'h04);
    do_cyc(1, 0, 0);
    do_cyc(0, 1, 3);
    // priority and tie
    irq_prio = '0;
    set_prio(1, 3);
    set_prio(4, 3);
    set_prio(6, 2);
    pulse(8'h52);
    step();
    do_cyc(1, 0, 0);
    chk("pt_id1", bus.claim_id_o, 2);
    do_cyc(1, 0, 0);
    chk("pt_id2", bus.claim_id_o, 5);
    do_cyc(1, 0, 0);
    chk("pt_id3", bus.claim_id_o, 7);
    chk("pt_eip", bus.eip_o, 1);
    step();
    chk("pt_eip_clr", bus.eip_o, 0);
    do_cyc(0, 1, 2);
    do_cyc(0, 1, 5);
    do_cyc(0, 1, 7);
    // threshold
    irq_prio = '0;
    set_prio(0, 2);
    prio_thresh = 3'd2;
    pulse(8'h01);
    step();
    chk("th_eip0", bus.eip_o, 0);
    do_cyc(1, 0, 0);
    chk("th_ack", bus.claim_ack_o, 1);
    chk("th_id", bus.claim_id_o, NMI ? 1 : 0);
    prio_thresh = 3'd1;
    step();
    chk("th_eip1", bus.eip_o, NMI ? 0 : 1);
    do_cyc(1, 0, 0);
    do_cyc(0, 1, 1);
    // level re-arm
    irq_prio = '0;
    set_prio(3, 4);
    prio_thresh = 3'd0;
    irq_req = 8'h08;
    step();
    step();
    do_cyc(1, 0, 0);
    chk("lv_id", bus.claim_id_o, 4);
    do_cyc(1, 0, 0);
    chk("lv_ack2", bus.claim_ack_o, 1);
    chk("lv_id2", bus.claim_id_o, 0);
    do_cyc(0, 1, 4);
    step();
    chk("lv_pend", pending_o, 8'h08);
    step();
    chk("lv_eip", bus.eip_o, 1);
    irq_req = '0;
    do_cyc(1, 0, 0);
    do_cyc(0, 1, 4);
    // bad complete and simultaneous claim + complete
    irq_prio = '0;
    set_prio(5, 6);
    set_prio(2, 3);
    pulse(8'h24);
    step();
    do_cyc(1, 0, 0);
    chk("bc_id", bus.claim_id_o, 6);
    do_cyc(0, 1, 9);
    do_cyc(0, 1, 2);
    chk("bc_pend", pending_o, 8'h04);
    chk("bc_eip", bus.eip_o, 1);
    do_cyc(1, 1, 6);
    chk("sim_id", bus.claim_id_o, 3);
    chk("sim_pend", pending_o, 0);
    pulse(8'h20);
    chk("sim_rearm", pending_o, 8'h20);
    do_cyc(1, 0, 0);
    do_cyc(0, 1, 6);
    do_cyc(0, 1, 3);
    // reset mid-service
    irq_prio = '0;
    set_prio(1, 5);
    pulse(8'h02);
    step();
    do_cyc(1, 0, 0);
    chk("rs_id", bus.claim_id_o, 2);
    preset = 1'b1;
    step();
    preset = 1'b0;
    chk("rs_eip", bus.eip_o, 0);
    chk("rs_ack", bus.claim_ack_o, 0);
    chk("rs_id0", bus.claim_id_o, 0);
    chk("rs_pend", pending_o, 0);
    pulse(8'h02);
    chk("rs_rearm", pending_o, 8'h02);
    do_cyc(1, 0, 0);
    do_cyc(0, 1, 2);
`ifdef PLIC_NMI_BYPASS_EN
    irq_prio = '0;
    prio_thresh = 3'd7;
    pulse(8'h01);
    step();
    chk("nmi_out", nmi, 1);
    chk("nmi_eip", bus.eip_o, 0);
    do_cyc(1, 0, 0);
    chk("nmi_id", bus.claim_id_o, 1);
    do_cyc(0, 1, 1);
`endif
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        irq_prio = 24'($urandom);
        prio_thresh = 3'($urandom_range(0, 4));
      end
      irq_req = 8'($urandom) & 8'($urandom);
      bus.claim_i = $urandom_range(0, 3) == 0;
      bus.complete_i = $urandom_range(0, 2) == 0;
      bus.complete_id = 4'($urandom_range(0, 9));
      preset = $urandom_range(0, 299) == 0;
      step();
    end
    preset = 1'b0;
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b0;
    irq_req = '0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
